// File: rtl/logic_proc_n.sv
// Bit-serial two-register logic processor: computes f(A,B) one bit per clock and routes the result.
// Optional LOGIC_PROC_ITER_EN adds input i_Iter for (Iter+1) back-to-back passes per operation.
module logic_proc_n #(
    parameter int WIDTH = 8
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             i_LoadA,
    input  logic             i_LoadB,
    input  logic             i_Execute,
    input  logic [WIDTH-1:0] i_Din,
    input  logic [2:0]       i_F,
    input  logic [1:0]       i_R,
`ifdef LOGIC_PROC_ITER_EN
    input  logic [3:0]       i_Iter,
`endif
    output logic [WIDTH-1:0] o_Aval,
    output logic [WIDTH-1:0] o_Bval,
    output logic             o_Busy,
    output logic             o_Done
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_f;
    logic [1:0]       r_r;
    logic             r_exec_q;
    logic             r_busy;
    logic             r_done;
`ifdef LOGIC_PROC_ITER_EN
    logic [3:0]       r_iter;
    logic [3:0]       r_pass;
`endif

    logic             w_exec_edge;
    logic             w_bit;
    logic             w_last_pass;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;

    function automatic logic logic_fn(input logic [2:0] f, input logic a, input logic b);
        case (f)
            3'b000:  logic_fn = a & b;
            3'b001:  logic_fn = a | b;
            3'b010:  logic_fn = a ^ b;
            3'b011:  logic_fn = 1'b1;
            3'b100:  logic_fn = ~(a & b);
            3'b101:  logic_fn = ~(a | b);
            3'b110:  logic_fn = ~(a ^ b);
            default: logic_fn = 1'b0;
        endcase
    endfunction

    assign w_exec_edge = i_Execute & ~r_exec_q;
    assign w_bit       = logic_fn(r_f, r_a[0], r_b[0]);

`ifdef LOGIC_PROC_ITER_EN
    assign w_last_pass = (r_pass == r_iter);
`else
    assign w_last_pass = 1'b1;
`endif

    // Next register values for one shift step, selected by the latched routing code.
    always_comb begin
        w_a_nxt = {r_a[0], r_a[WIDTH-1:1]};
        w_b_nxt = {r_b[0], r_b[WIDTH-1:1]};
        case (r_r)
            2'b01: w_b_nxt = {w_bit, r_b[WIDTH-1:1]};
            2'b10: w_a_nxt = {w_bit, r_a[WIDTH-1:1]};
            2'b11: begin
                w_a_nxt = {r_b[0], r_a[WIDTH-1:1]};
                w_b_nxt = {r_a[0], r_b[WIDTH-1:1]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_f      <= '0;
            r_r      <= '0;
            r_exec_q <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef LOGIC_PROC_ITER_EN
            r_iter   <= '0;
            r_pass   <= '0;
`endif
        end else begin
            r_exec_q <= i_Execute;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_exec_edge) begin
                        r_f     <= i_F;
                        r_r     <= i_R;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
`ifdef LOGIC_PROC_ITER_EN
                        r_iter  <= i_Iter;
                        r_pass  <= '0;
`endif
                    end else begin
                        if (i_LoadA) r_a <= i_Din;
                        if (i_LoadB) r_b <= i_Din;
                    end
                end
                S_SHIFT: begin
                    r_a <= w_a_nxt;
                    r_b <= w_b_nxt;
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        if (w_last_pass) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
`ifdef LOGIC_PROC_ITER_EN
                        else begin
                            r_pass <= r_pass + 4'd1;
                        end
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_Aval = r_a;
    assign o_Bval = r_b;
    assign o_Busy = r_busy;
    assign o_Done = r_done;

endmodule

// File: doc/logic_proc_n.md
LOGIC_PROC_N -- requirements
Module: logic_proc_n

Interface
REQ-001 Parameter WIDTH, default 8, register and data width in bits; legal range 2..32.
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 LoadA  input  1  active-high; load Din into register A.
REQ-005 LoadB  input  1  active-high; load Din into register B.
REQ-006 Execute  input  1  active-high level; each rising edge requests one operation.
REQ-007 Din  input  WIDTH  load data.
REQ-008 F  input  3  function select: 000 AND, 001 OR, 010 XOR, 011 ones, 100 NAND, 101 NOR, 110 XNOR, 111 zeros.
REQ-009 R  input  2  routing: 00 none, 01 result->B, 10 result->A, 11 swap A/B.
REQ-010 Aval  output  WIDTH  register A contents.
REQ-011 Bval  output  WIDTH  register B contents.
REQ-012 Busy  output  1  high while state is SHIFT or DONE.
REQ-013 Done  output  1  one-cycle pulse on completion.

Function
REQ-014 FSM states: IDLE, SHIFT, DONE.
REQ-015 Execute rising edge = Execute high and registered exec_q low; exec_q updates every cycle.
REQ-016 IDLE, edge detected: latch F and R, clear bit counter, go to SHIFT.
REQ-017 IDLE, no edge: LoadA loads A from Din; LoadB loads B from Din; both asserted load both.
REQ-018 Load asserted in the same cycle as a detected edge: load ignored, operation starts.
REQ-019 SHIFT: one bit per cycle; bit = f(A[0],B[0]) using the latched F.
REQ-020 R=00: A and B rotate right by one.
REQ-021 R=10: A <= {bit, A[WIDTH-1:1]}; B rotates right.
REQ-022 R=01: B <= {bit, B[WIDTH-1:1]}; A rotates right.
REQ-023 R=11: A <= {B[0], A[WIDTH-1:1]}; B <= {A[0], B[WIDTH-1:1]}.
REQ-024 After exactly WIDTH shift edges (counter WIDTH-1 to terminal), go to DONE; counter width $clog2(WIDTH).
REQ-025 DONE: Done=1 for exactly one cycle, then IDLE; Aval/Bval hold the final result from DONE onward.
REQ-026 Latency: edge detected at clock edge k; shifts at edges k+1..k+WIDTH; Done high in cycle k+WIDTH to k+WIDTH+1; Busy low again after edge k+WIDTH+1.
REQ-027 During SHIFT/DONE: LoadA, LoadB, F, R and new Execute edges are ignored, not queued.
REQ-028 Execute held high across completion does not start a second operation.

Reset
REQ-029 Reset has priority over all other inputs, in any state.
REQ-030 Reset values: A=0, B=0, state IDLE, counter 0, Busy=0, Done=0, latched F/R=0.
REQ-031 exec_q resets to 1, so Execute held high through reset release does not trigger an operation.
REQ-032 Reset mid-SHIFT aborts the operation; no Done pulse is produced.

Configuration
REQ-033 Macro LOGIC_PROC_ITER_EN defined: add input Iter [3:0]; Iter is latched at start; operation runs (Iter+1)*WIDTH back-to-back shift cycles with no idle gap; a single Done follows the last pass.
REQ-034 Macro LOGIC_PROC_ITER_EN undefined: port Iter absent; exactly one WIDTH-cycle pass per operation.

Verification
REQ-035 WIDTH=8: A=33h, B=55h, F=010, R=10, pulse Execute -> Done in cycle k+8; A=66h, B=55h.
REQ-036 Continue: F=110, R=01, Execute -> A=66h, B=CCh; then R=11, Execute -> A=CCh, B=66h.
REQ-037 F=011, R=10, with Execute held high 30 cycles -> A=FFh, exactly one Done pulse, Busy high 9 cycles.
REQ-038 LoadA with Din=AAh during SHIFT -> ignored; Reset at shift 4 -> A=B=00h, Busy=0, no Done pulse.
REQ-039 LOGIC_PROC_ITER_EN, WIDTH=16, Iter=2, A=1234h, B=00FFh, F=010, R=10 -> A=12CBh after 48 shifts, single Done.
